// File: rtl/chip_link_rx.sv
// Off-chip link receiver: four-phase flit handshake with parity check, assembling FLITS flits MSB-first into one packet.
// Ack rises 4 edges after valid is first sampled; a full packet held by the router stalls the ack of the next packet's last flit.
module chip_link_rx #(
  parameter int CHIPDATA_WIDTH = 16,
  parameter int PKT_WIDTH      = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHIPDATA_WIDTH-1:0] recv_data_in,
  input  logic                      recv_data_valid,
  input  logic                      recv_data_par,
  output logic                      recv_data_ready,
  output logic                      recv_data_err,
  output logic [PKT_WIDTH-1:0]      pkt_data,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output logic [7:0]                err_cnt
);

  localparam int FLITS = PKT_WIDTH / CHIPDATA_WIDTH;
  localparam int IDX_W = (FLITS > 1) ? $clog2(FLITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FLITS - 1);

  if (PKT_WIDTH % CHIPDATA_WIDTH != 0) begin : g_bad_width
    $error("chip_link_rx: PKT_WIDTH must be a multiple of CHIPDATA_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CHECK, ACK} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                sync_q, sync_d;
  logic [CHIPDATA_WIDTH-1:0] flit_q, flit_d;
  logic                      par_q, par_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [PKT_WIDTH-1:0]      asm_q, asm_d;
  logic                      ready_q, ready_d;
  logic                      err_q, err_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [PKT_WIDTH-1:0]      pkt_data_q, pkt_data_d;
  logic                      pkt_valid_q, pkt_valid_d;
  logic [PKT_WIDTH-1:0]      full_pkt;
  logic                      valid_s;

  assign valid_s = sync_q[1];

  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], recv_data_valid};
    flit_d      = flit_q;
    par_d       = par_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    ready_d     = ready_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    pkt_data_d  = pkt_data_q;
    pkt_valid_d = pkt_valid_q & ~pkt_ready;
    // The last flit goes straight into the packet; it is never written to asm_q.
    full_pkt                   = asm_q;
    full_pkt[CHIPDATA_WIDTH-1:0] = flit_q;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b0;
        err_d   = 1'b0;
        if (valid_s) begin
          flit_d  = recv_data_in;
          par_d   = recv_data_par;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((^flit_q) != par_q) begin
          err_d   = 1'b1;
          ready_d = 1'b1;
          cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          state_d = ACK;
        end else if (idx_q != LAST_IDX) begin
          for (int i = 0; i < FLITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              asm_d[PKT_WIDTH-1-i*CHIPDATA_WIDTH -: CHIPDATA_WIDTH] = flit_q;
            end
          end
          idx_d   = idx_q + IDX_W'(1);
          ready_d = 1'b1;
          err_d   = 1'b0;
          state_d = ACK;
        end else if (!pkt_valid_q || pkt_ready) begin
          pkt_data_d  = full_pkt;
          pkt_valid_d = 1'b1;
          idx_d       = '0;
          ready_d     = 1'b1;
          err_d       = 1'b0;
          state_d     = ACK;
        end
      end
      ACK: begin
        if (!valid_s) begin
          ready_d = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '0;
      flit_q      <= '0;
      par_q       <= 1'b0;
      idx_q       <= '0;
      asm_q       <= '0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      pkt_data_q  <= '0;
      pkt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      flit_q      <= flit_d;
      par_q       <= par_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
    end
  end

  assign recv_data_ready = ready_q;
  assign recv_data_err   = err_q;
  assign pkt_data        = pkt_data_q;
  assign pkt_valid       = pkt_valid_q;
  assign err_cnt         = cnt_q;

endmodule

// File: doc/chip_link_rx.md
CHIP_LINK_RX -- requirements
Module: chip_link_rx

Interface
REQ-001 Parameter CHIPDATA_WIDTH, default 16, width of one off-chip flit.
REQ-002 Parameter PKT_WIDTH, default 64, packet width; FLITS = PKT_WIDTH/CHIPDATA_WIDTH (4); PKT_WIDTH SHALL be an integer multiple of CHIPDATA_WIDTH.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 recv_data_in  input  CHIPDATA_WIDTH  flit from neighbouring chip, stable while recv_data_valid=1.
REQ-006 recv_data_valid  input  1  four-phase request from neighbouring chip, asynchronous to clk.
REQ-007 recv_data_par  input  1  even parity of recv_data_in (par = XOR of all data bits).
REQ-008 recv_data_ready  output  1  four-phase acknowledge to neighbouring chip.
REQ-009 recv_data_err  output  1  parity-error flag, valid while recv_data_ready=1.
REQ-010 pkt_data  output  PKT_WIDTH  assembled packet to on-chip router.
REQ-011 pkt_valid  output  1  pkt_data holds an unconsumed packet.
REQ-012 pkt_ready  input  1  router accepts packet; transfer when pkt_valid & pkt_ready at a rising edge.
REQ-013 err_cnt  output  8  count of parity-errored flits, saturating.

Function
REQ-014 recv_data_valid SHALL pass through a 2-flop synchronizer; FSM uses only synchronized value valid_s.
REQ-015 FSM states IDLE, CHECK, ACK; reset state IDLE.
REQ-016 IDLE: ready=0, err=0; on valid_s=1 capture recv_data_in and recv_data_par into flit register, go CHECK.
REQ-017 CHECK, parity mismatch: set err=1, ready=1, increment err_cnt (hold at 255), do not store flit, keep flit index, go ACK.
REQ-018 CHECK, parity OK, flit index < FLITS-1: store flit, index+1, set ready=1, err=0, go ACK.
REQ-019 CHECK, parity OK, last flit, and (pkt_valid=0 or pkt_ready=1): load complete packet into pkt_data, pkt_valid=1, index=0, ready=1, go ACK.
REQ-020 CHECK, parity OK, last flit, pkt_valid=1 and pkt_ready=0: stay CHECK, ready stays 0 (back-pressure to neighbouring chip).
REQ-021 ACK: hold ready=1 and err; on valid_s=0 clear ready and err, go IDLE.
REQ-022 Flit order MSB first: flit 0 -> pkt_data[PKT_WIDTH-1 -: CHIPDATA_WIDTH], flit FLITS-1 -> pkt_data[CHIPDATA_WIDTH-1:0].
REQ-023 Errored flit SHALL be resent by the neighbour; retry fills the same index.
REQ-024 pkt_valid SHALL clear on pkt_valid & pkt_ready unless a new packet loads on the same edge (REQ-019), in which case pkt_valid stays 1 with the new pkt_data.
REQ-025 pkt_data SHALL be unchanged while pkt_valid=1 and pkt_ready=0.
REQ-026 Latency: recv_data_ready rises after the 4th rising edge from the first edge sampling recv_data_valid=1 (no stall); falls after the 3rd rising edge from the first edge sampling recv_data_valid=0.
REQ-027 All outputs registered; no combinational path from any input to any output.

Reset
REQ-028 rst_n=0 SHALL immediately force recv_data_ready=0, recv_data_err=0, pkt_valid=0, pkt_data=0, err_cnt=0, synchronizer=0, flit index=0, FSM=IDLE.
REQ-029 Reset mid-packet or mid-handshake SHALL discard partially assembled flits; first flit after reset lands at index 0.

Verification
REQ-030 Four clean flits 0x1234,0x5678,0x9ABC,0xDEF0 with pkt_ready=1 -> one pkt_valid pulse, pkt_data=0x123456789ABCDEF0, err_cnt=0.
REQ-031 Flit 2 sent with inverted parity, then resent correctly -> recv_data_err=1 during that ack only, err_cnt=1, final packet correct.
REQ-032 pkt_ready=0, two packets sent -> first packet held stable, 4th flit of second packet not acknowledged until pkt_ready=1, then both delivered in order.
REQ-033 rst_n pulsed low after 2 flits, then 4 new flits -> pkt_data equals only the new 4 flits, all outputs 0 during reset.
REQ-034 260 errored flits -> err_cnt saturates at 255, no packet emitted.
REQ-035 Single flit with recv_data_valid rising at edge N -> recv_data_ready=1 after edge N+3; valid dropped at edge M -> ready=0 after edge M+2.
